// File: rtl/cache_controller_if.sv
// Request/response bus between a cache_controller (master) and one memory_subsystem port (slave).
interface cache_controller_if #(
    parameter int unsigned DATA_SIZE = 2
) ();
    logic                   processor_req;
    logic                   mem_read_req;
    logic                   mem_write_req;
    logic [13:0]            addr;
    logic [DATA_SIZE*8-1:0] mem_write_data;
    logic [DATA_SIZE*8-1:0] mem_read_data;
    logic                   processor_resp;

    modport master (
        output processor_req,
        output mem_read_req,
        output mem_write_req,
        output addr,
        output mem_write_data,
        input  mem_read_data,
        input  processor_resp
    );

    modport slave (
        input  processor_req,
        input  mem_read_req,
        input  mem_write_req,
        input  addr,
        input  mem_write_data,
        output mem_read_data,
        output processor_resp
    );
endinterface

// File: rtl/cache_controller.sv
// Direct-mapped, write-back, write-allocate cache with one word per line (I/S/M), serving one CPU
// and acting as initiator on a memory-subsystem port. Handles fills, dirty write-backs, flush, timeout.
module cache_controller #(
    parameter int unsigned DATA_SIZE = 2,
    parameter int unsigned NUM_LINES = 8,
    parameter int unsigned TIMEOUT   = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   cpu_req,
    input  logic                   cpu_we,
    input  logic [13:0]            cpu_addr,
    input  logic [DATA_SIZE*8-1:0] cpu_wdata,
    input  logic                   cpu_flush,
    output logic                   cpu_ready,
    output logic                   cpu_done,
    output logic [DATA_SIZE*8-1:0] cpu_rdata,
    output logic                   cpu_err,
    cache_controller_if.master     bus
);
    localparam int unsigned DW    = DATA_SIZE * 8;
    localparam int unsigned IDX_W = $clog2(NUM_LINES);
    localparam int unsigned TAG_W = 14 - IDX_W;
    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    localparam logic [1:0] LINE_I = 2'b00;
    localparam logic [1:0] LINE_M = 2'b01;
    localparam logic [1:0] LINE_S = 2'b10;

    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_LINES - 1);
    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        StIdle,
        StWb,
        StGap,
        StFill,
        StFlScan,
        StFlWb,
        StFlGap
    } state_e;

    state_e st_q;

    logic [DW-1:0]    line_data_q [NUM_LINES];
    logic [TAG_W-1:0] line_tag_q  [NUM_LINES];
    logic [1:0]       line_st_q   [NUM_LINES];

    logic             req_we_q;
    logic [13:0]      req_addr_q;
    logic [DW-1:0]    req_wdata_q;
    logic [IDX_W-1:0] vic_idx_q;
    logic [IDX_W-1:0] fl_idx_q;
    logic [CNT_W-1:0] wait_q;

    logic             ready_q;
    logic             done_q;
    logic             err_q;
    logic [DW-1:0]    rdata_q;
    logic             breq_q;
    logic             brd_q;
    logic             bwr_q;
    logic [13:0]      baddr_q;
    logic [DW-1:0]    bwdata_q;

    logic [IDX_W-1:0] in_idx;
    logic [TAG_W-1:0] in_tag;
    logic             in_hit;
    logic [IDX_W-1:0] req_idx;
    logic [TAG_W-1:0] req_tag;
    logic             wait_expired;

    assign in_idx       = cpu_addr[IDX_W-1:0];
    assign in_tag       = cpu_addr[13:IDX_W];
    assign in_hit       = (line_st_q[in_idx] != LINE_I) && (line_tag_q[in_idx] == in_tag);
    assign req_idx      = req_addr_q[IDX_W-1:0];
    assign req_tag      = req_addr_q[13:IDX_W];
    // Last waiting cycle without a response: the bus is released at this edge.
    assign wait_expired = !bus.processor_resp && (wait_q == WAIT_LAST);

    assign cpu_ready          = ready_q;
    assign cpu_done           = done_q;
    assign cpu_err            = err_q;
    assign cpu_rdata          = rdata_q;
    assign bus.processor_req  = breq_q;
    assign bus.mem_read_req   = brd_q;
    assign bus.mem_write_req  = bwr_q;
    assign bus.addr           = baddr_q;
    assign bus.mem_write_data = bwdata_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            st_q        <= StIdle;
            req_we_q    <= 1'b0;
            req_addr_q  <= '0;
            req_wdata_q <= '0;
            vic_idx_q   <= '0;
            fl_idx_q    <= '0;
            wait_q      <= '0;
            ready_q     <= 1'b1;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            rdata_q     <= '0;
            breq_q      <= 1'b0;
            brd_q       <= 1'b0;
            bwr_q       <= 1'b0;
            baddr_q     <= '0;
            bwdata_q    <= '0;
            for (int i = 0; i < int'(NUM_LINES); i++) begin
                line_data_q[i] <= '0;
                line_tag_q[i]  <= '0;
                line_st_q[i]   <= LINE_I;
            end
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            unique case (st_q)
                StIdle: begin
                    if (cpu_req) begin
                        req_we_q    <= cpu_we;
                        req_addr_q  <= cpu_addr;
                        req_wdata_q <= cpu_wdata;
                        if (in_hit) begin
                            done_q <= 1'b1;
                            if (cpu_we) begin
                                line_data_q[in_idx] <= cpu_wdata;
                                line_st_q[in_idx]   <= LINE_M;
                            end else begin
                                rdata_q <= line_data_q[in_idx];
                            end
                        end else if (line_st_q[in_idx] == LINE_M) begin
                            st_q      <= StWb;
                            ready_q   <= 1'b0;
                            vic_idx_q <= in_idx;
                            wait_q    <= '0;
                            breq_q    <= 1'b1;
                            bwr_q     <= 1'b1;
                            baddr_q   <= {line_tag_q[in_idx], in_idx};
                            bwdata_q  <= line_data_q[in_idx];
                        end else if (cpu_we) begin
                            line_data_q[in_idx] <= cpu_wdata;
                            line_tag_q[in_idx]  <= in_tag;
                            line_st_q[in_idx]   <= LINE_M;
                            done_q              <= 1'b1;
                        end else begin
                            st_q    <= StFill;
                            ready_q <= 1'b0;
                            wait_q  <= '0;
                            breq_q  <= 1'b1;
                            brd_q   <= 1'b1;
                            baddr_q <= cpu_addr;
                        end
                    end else if (cpu_flush) begin
                        st_q     <= StFlScan;
                        ready_q  <= 1'b0;
                        fl_idx_q <= '0;
                    end
                end

                // Demand and flush write-backs share the bus sequence; only the victim's
                // final state and the follow-on state differ.
                StWb, StFlWb: begin
                    if (bus.processor_resp) begin
                        line_st_q[vic_idx_q] <= (st_q == StWb) ? LINE_I : LINE_S;
                        st_q     <= (st_q == StWb) ? StGap : StFlGap;
                        breq_q   <= 1'b0;
                        bwr_q    <= 1'b0;
                        baddr_q  <= '0;
                        bwdata_q <= '0;
                    end else if (wait_expired) begin
                        st_q     <= StIdle;
                        ready_q  <= 1'b1;
                        done_q   <= 1'b1;
                        err_q    <= 1'b1;
                        breq_q   <= 1'b0;
                        bwr_q    <= 1'b0;
                        baddr_q  <= '0;
                        bwdata_q <= '0;
                    end else begin
                        wait_q <= wait_q + CNT_W'(1);
                    end
                end

                StGap: begin
                    if (req_we_q) begin
                        line_data_q[req_idx] <= req_wdata_q;
                        line_tag_q[req_idx]  <= req_tag;
                        line_st_q[req_idx]   <= LINE_M;
                        st_q                 <= StIdle;
                        ready_q              <= 1'b1;
                        done_q               <= 1'b1;
                    end else begin
                        st_q    <= StFill;
                        wait_q  <= '0;
                        breq_q  <= 1'b1;
                        brd_q   <= 1'b1;
                        baddr_q <= req_addr_q;
                    end
                end

                StFill: begin
                    if (bus.processor_resp) begin
                        line_data_q[req_idx] <= bus.mem_read_data;
                        line_tag_q[req_idx]  <= req_tag;
                        line_st_q[req_idx]   <= LINE_S;
                        rdata_q              <= bus.mem_read_data;
                        st_q                 <= StIdle;
                        ready_q              <= 1'b1;
                        done_q               <= 1'b1;
                        breq_q               <= 1'b0;
                        brd_q                <= 1'b0;
                        baddr_q              <= '0;
                    end else if (wait_expired) begin
                        st_q    <= StIdle;
                        ready_q <= 1'b1;
                        done_q  <= 1'b1;
                        err_q   <= 1'b1;
                        breq_q  <= 1'b0;
                        brd_q   <= 1'b0;
                        baddr_q <= '0;
                    end else begin
                        wait_q <= wait_q + CNT_W'(1);
                    end
                end

                StFlScan: begin
                    if (line_st_q[fl_idx_q] == LINE_M) begin
                        st_q      <= StFlWb;
                        vic_idx_q <= fl_idx_q;
                        wait_q    <= '0;
                        breq_q    <= 1'b1;
                        bwr_q     <= 1'b1;
                        baddr_q   <= {line_tag_q[fl_idx_q], fl_idx_q};
                        bwdata_q  <= line_data_q[fl_idx_q];
                    end else if (fl_idx_q == LAST_IDX) begin
                        st_q    <= StIdle;
                        ready_q <= 1'b1;
                        done_q  <= 1'b1;
                    end else begin
                        fl_idx_q <= fl_idx_q + IDX_W'(1);
                    end
                end

                // Finishing here when the last line was dirty keeps the index from wrapping.
                StFlGap: begin
                    if (fl_idx_q == LAST_IDX) begin
                        st_q    <= StIdle;
                        ready_q <= 1'b1;
                        done_q  <= 1'b1;
                    end else begin
                        st_q     <= StFlScan;
                        fl_idx_q <= fl_idx_q + IDX_W'(1);
                    end
                end

                default: st_q <= StIdle;
            endcase
        end
    end
endmodule

// File: doc/cache_controller.md
# cache_controller

Processor-side initiator for the shared `memory_subsystem` port: a small direct-mapped, write-back, write-allocate cache. Each line holds one memory word and an I/S/M state. It serves one CPU's load/store requests and issues `processor_req` / `mem_read_req` / `mem_write_req` transactions to one of the four memory-subsystem ports. It also handles fills, dirty-victim write-backs, a bus timeout and a full-cache flush. One instance per processor.

## Interface
- `DATA_SIZE`, 2: bytes per word; data width is DATA_SIZE*8.
- `NUM_LINES`, 8: number of cache lines; must be a power of two ≥2. IDX_W = log2(NUM_LINES).
- `TIMEOUT`, 16: maximum cycles to wait for `processor_resp` (≥2).
- `clk`  in  1  single clock; all logic on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `cpu_req`  in  1  CPU request strobe; sampled only while `cpu_ready`=1.
- `cpu_we`  in  1  1=store, 0=load.
- `cpu_addr`  in  14  word address.
- `cpu_wdata`  in  DATA_SIZE*8  store data.
- `cpu_flush`  in  1  flush request; sampled only while `cpu_ready`=1 and `cpu_req`=0.
- `cpu_ready`  out  1  controller idle; a request can be accepted.
- `cpu_done`  out  1  one-cycle completion pulse.
- `cpu_rdata`  out  DATA_SIZE*8  load data; valid while `cpu_done`=1 for a load, otherwise holds its value.
- `cpu_err`  out  1  valid with `cpu_done`; 1 = bus timeout.
- `processor_req`  out  1  bus request to the memory subsystem.
- `mem_read_req`  out  1  read qualifier.
- `mem_write_req`  out  1  write qualifier.
- `addr`  out  14  bus word address.
- `mem_write_data`  out  DATA_SIZE*8  write-back data.
- `mem_read_data`  in  DATA_SIZE*8  fill data; sampled in the cycle `processor_resp`=1.
- `processor_resp`  in  1  grant/response from the memory subsystem.

## Operation
- Address split:
  - index = `cpu_addr`[IDX_W-1:0]
  - tag = `cpu_addr`[13:IDX_W]
  - Hit = state≠I and tag match.
- Per-line storage: data, tag, and a 2-bit state: I=00, M=01, S=10. Encoding matches the memory subsystem.
- States: IDLE, WB, GAP, FILL, FL_SCAN, FL_WB, FL_GAP.
- IDLE behaviour (`cpu_ready`=1). On `cpu_req`, latch we/addr/wdata. Then:
  - Load hit: return line data, go to IDLE.
  - Store hit: write data, set state=M. No bus operation; S→M is silent.
  - Miss with victim M: go to WB.
  - Load miss with victim I/S: go to FILL.
  - Store miss with victim I/S: install tag/data as M, go to IDLE.
  - `cpu_flush` with no `cpu_req`: index counter=0, go to FL_SCAN.
- WB:
  - Drive `processor_req`=1, `mem_write_req`=1, `addr`={victim tag, index}, `mem_write_data`=victim data.
  - On `processor_resp`, the victim becomes I, then go to GAP.
- GAP: one cycle with all bus outputs 0. Then:
  - Load: go to FILL.
  - Store: install the line as M, signal done, go to IDLE.
- FILL:
  - Drive `processor_req`=1, `mem_read_req`=1, `addr`=request address.
  - On `processor_resp`, write `mem_read_data` into the line with state S, set `cpu_rdata`=`mem_read_data`, signal done.
- FL_SCAN:
  - One index per cycle.
  - If the line is M, go to FL_WB.
  - Otherwise increment the index. After index NUM_LINES-1, signal done and go to IDLE.
- FL_WB / FL_GAP:
  - FL_WB performs the same write-back as WB, but the line becomes S (clean), not I.
  - FL_GAP is one idle bus cycle, then increment the index and return to FL_SCAN.
- `mem_read_req` and `mem_write_req` are never both 1.
- Bus outputs are 0 whenever `processor_req`=0.
- Timeout:
  - A wait counter clears on entry to WB, FILL and FL_WB, and increments each cycle `processor_resp`=0.
  - When the counter reaches TIMEOUT, drop all bus outputs next cycle and signal done with `cpu_err`=1.
  - Line state, tag and data are left unchanged.
  - Go to IDLE, including mid-flush; the flush is aborted.
- `processor_resp` while `processor_req`=0 is ignored.

## Timing
- All outputs are registered.
- Reset values:
  - All outputs 0, except `cpu_ready`=1.
  - `cpu_rdata`=0.
  - All lines state=I, tag=0, data=0.
  - FSM in IDLE, counters 0.
- Reset in any state:
  - Applies the next edge, including mid-transaction; `processor_req` falls in the cycle after the reset edge.
  - Reset overrides a coincident `processor_resp`.
- Request accepted at edge k:
  - `cpu_ready`=0 from cycle k+1 until the cycle `cpu_done`=1.
  - `cpu_ready` returns to 1 together with `cpu_done`.
- Hit or clean store miss: `cpu_done`=1 in cycle k+1.
- Clean load miss:
  - `processor_req`=1 from cycle k+1.
  - `processor_resp` is seen in cycle r; `cpu_done` is asserted in cycle r+1.
- Dirty miss:
  - WB runs from cycle k+1 until resp in cycle r.
  - Cycle r+1 is GAP; FILL starts in cycle r+2.
  - A store completes in cycle r+2.
- Timeout: if no resp is seen, `processor_req` is high for exactly TIMEOUT cycles and `cpu_done`/`cpu_err` follow in the next cycle.
- `cpu_done` and `cpu_err` are high for exactly one cycle.

## Test plan
- Read miss and hit:
  - Stimulus: after reset, load addr 5; memory model responds 2 cycles later with 0x0006.
  - Required: FILL with `addr`=5 and `mem_read_req`=1; `cpu_rdata`=0x0006, `cpu_err`=0.
  - Required on a repeat load of 5: `cpu_done` at k+1 and no `processor_req`.
- Silent write hit:
  - Stimulus: store 0xBEEF to addr 5, then load addr 5.
  - Required: no bus activity; the load returns 0xBEEF in 1 cycle.
- Dirty eviction:
  - Stimulus: continuing the previous scenario, load addr 13 (index 5).
  - Required: WB with `addr`=5, `mem_write_data`=0xBEEF, `mem_write_req`=1; one GAP cycle with `processor_req`=0; then FILL with `addr`=13.
- Timeout:
  - Stimulus: memory model never asserts `processor_resp` on a load miss to addr 2.
  - Required: `processor_req` high for 16 cycles, then `cpu_done`=1 with `cpu_err`=1; line 2 still I.
- Flush:
  - Stimulus: lines 1 and 6 in state M, then pulse `cpu_flush`.
  - Required: exactly two write-backs, index 1 then 6, each followed by a GAP cycle; one `cpu_done` after index 7.
  - Required on a second flush: no bus operations.
- Reset mid-FILL:
  - Stimulus: assert `reset` during FILL.
  - Required: `processor_req`=0 in the next cycle and `cpu_ready`=1; a subsequent load of the previously filled address misses.
